// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline.
// Freeze on SRAM access beats branch squash, which beats RAW stall.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fwd_en,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch_taken,
    input  logic             sram_ack,
    output logic             sram_req,
    output logic             sram_we,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idexe_en,
    output logic             exemem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idexe_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t state;

    logic mem_access;
    logic freeze;
    logic exe_match;
    logic mem_match;
    logic hazard;

    function automatic logic src_match(input logic [4:0] dest);
        return (dest != 5'd0) &&
               ((dest == id_src1) ||
                (id_two_src && (dest == id_src2)));
    endfunction

    assign mem_access = mem_read | mem_write;
    // RELEASE ignores the MEM flags: they belong to the finished access
    assign freeze = (state == S_WAIT) ||
                    ((state == S_RUN) && mem_access);

    assign exe_match = src_match(exe_dest);
    assign mem_match = src_match(mem_dest);

    always_comb begin
        hazard = 1'b0;
        if (fwd_en)
            hazard = exe_mem_read && exe_wb_en && exe_match;
        else
            hazard = (exe_wb_en && exe_match) ||
                     (mem_wb_en && mem_match);
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idexe_en    = 1'b1;
        exemem_en   = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        priority case (1'b1)
            freeze: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idexe_en  = 1'b0;
                exemem_en = 1'b0;
                memwb_en  = 1'b0;
            end
            branch_taken: begin
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
            end
            hazard: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idexe_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_RUN;
            sram_req <= 1'b0;
            sram_we  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_access) begin
                        state    <= S_WAIT;
                        sram_req <= 1'b1;
                        sram_we  <= mem_write;
                    end
                end
                S_WAIT: begin
                    if (sram_ack) begin
                        state    <= S_RELEASE;
                        sram_req <= 1'b0;
                    end
                end
                S_RELEASE: state <= S_RUN;
                default: begin
                    state    <= S_RUN;
                    sram_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cycles <= '0;
        else if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a cycle-level model.
// Two instances share stimulus: default width and a 4-bit counter.
module tb_pipeline_ctrl;

    logic       clock;
    logic       reset;
    logic       fwd_en;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic       id_two_src;
    logic [4:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_read;
    logic [4:0] mem_dest;
    logic       mem_wb_en;
    logic       mem_read;
    logic       mem_write;
    logic       branch_taken;
    logic       sram_ack;

    logic        req16, we16, req4, we4;
    logic [6:0]  ctl16, ctl4;
    logic [15:0] stall16;
    logic [3:0]  stall4;

    int n_chk;
    int n_err;

    // model state
    logic m_busy;
    logic m_done;
    logic m_we;
    int   m_cnt16;
    int   m_cnt4;

    pipeline_ctrl dut16 (
        .clock(clock), .reset(reset), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_read(mem_read), .mem_write(mem_write),
        .branch_taken(branch_taken), .sram_ack(sram_ack),
        .sram_req(req16), .sram_we(we16),
        .pc_en(ctl16[6]), .ifid_en(ctl16[5]),
        .idexe_en(ctl16[4]), .exemem_en(ctl16[3]),
        .memwb_en(ctl16[2]), .ifid_flush(ctl16[1]),
        .idexe_flush(ctl16[0]), .stall_cycles(stall16)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_read(mem_read), .mem_write(mem_write),
        .branch_taken(branch_taken), .sram_ack(sram_ack),
        .sram_req(req4), .sram_we(we4),
        .pc_en(ctl4[6]), .ifid_en(ctl4[5]),
        .idexe_en(ctl4[4]), .exemem_en(ctl4[3]),
        .memwb_en(ctl4[2]), .ifid_flush(ctl4[1]),
        .idexe_flush(ctl4[0]), .stall_cycles(stall4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic reads(input logic [4:0] d);
        return d != 0 && (d == id_src1 ||
                          (id_two_src && d == id_src2));
    endfunction

    // {pc, ifid, idexe, exemem, memwb, ifid_fl, idexe_fl}
    function automatic logic [6:0] exp_ctl();
        logic frozen, raw, br, st;
        frozen = m_busy || (!m_done && (mem_read || mem_write));
        if (fwd_en)
            raw = exe_mem_read && exe_wb_en && reads(exe_dest);
        else
            raw = (exe_wb_en && reads(exe_dest)) ||
                  (mem_wb_en && reads(mem_dest));
        if (frozen) return 7'b0000000;
        br = branch_taken;
        st = !br && raw;
        return {!st, !st, 3'b111, br, br || st};
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_done  = 0;
        m_we    = 0;
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    task automatic idle();
        fwd_en       = 0;
        id_src1      = 0;
        id_src2      = 0;
        id_two_src   = 0;
        exe_dest     = 0;
        exe_wb_en    = 0;
        exe_mem_read = 0;
        mem_dest     = 0;
        mem_wb_en    = 0;
        mem_read     = 0;
        mem_write    = 0;
        branch_taken = 0;
        sram_ack     = 0;
    endtask

    // check the current cycle, advance one edge, back at negedge
    task automatic tick();
        logic [6:0] e;
        #1;
        e = exp_ctl();
        chk("ctl16", 32'(ctl16), 32'(e));
        chk("ctl4", 32'(ctl4), 32'(e));
        chk("req16", 32'(req16), 32'(m_busy));
        chk("req4", 32'(req4), 32'(m_busy));
        chk("we16", 32'(we16), 32'(m_we));
        chk("cnt16", 32'(stall16), 32'(m_cnt16));
        chk("cnt4", 32'(stall4), 32'(m_cnt4));
        @(posedge clock);
        if (!e[6]) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (m_busy) begin
            if (sram_ack) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (mem_read || mem_write) begin
            m_busy = 1;
            m_we   = mem_write;
        end
        @(negedge clock);
    endtask

    int base;

    initial begin
        n_chk = 0;
        n_err = 0;
        idle();
        reset = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1;

        // no hazard
        id_src1 = 3; exe_dest = 5; exe_wb_en = 1;
        tick();
        chk("nohaz_cnt", 32'(stall16), 0);

        // RAW on exe without forwarding
        exe_dest = 4; id_src1 = 4;
        tick();
        chk("raw_cnt", 32'(stall16), 1);
        id_src1 = 1; id_src2 = 4; id_two_src = 0;
        tick();
        id_two_src = 1;
        tick();
        exe_dest = 0; id_src1 = 0; id_src2 = 0;
        tick();
        exe_wb_en = 0; mem_wb_en = 1; mem_dest = 6; id_src1 = 6;
        tick();
        chk("raw_cnt2", 32'(stall16), 3);
        idle();

        // forwarding: ALU producer then load producer
        fwd_en = 1; exe_wb_en = 1; exe_dest = 7; id_src1 = 7;
        mem_wb_en = 1; mem_dest = 7;
        tick();
        exe_mem_read = 1;
        tick();
        chk("fwd_cnt", 32'(stall16), 4);
        idle();

        // load, ack in cycle 3
        base = int'(stall16);
        mem_read = 1;
        tick();
        tick();
        tick();
        sram_ack = 1;
        tick();
        sram_ack = 0;
        tick();
        mem_read = 0;
        tick();
        chk("ld_stalls", 32'(int'(stall16) - base), 4);
        chk("ld_we", 32'(we16), 0);

        // store with branch, ack in cycle 1
        mem_write = 1; branch_taken = 1;
        tick();
        chk("st_we", 32'(we16), 1);
        sram_ack = 1;
        tick();
        sram_ack = 0;
        tick();
        idle();
        tick();

        // reset while waiting
        mem_read = 1;
        tick();
        tick();
        #2;
        reset = 0;
        #1;
        chk("rst_req", 32'(req16), 0);
        chk("rst_cnt", 32'(stall16), 0);
        model_reset();
        @(negedge clock);
        idle();
        reset = 1;
        tick();

        // saturation of the narrow counter
        exe_wb_en = 1; exe_dest = 9; id_src1 = 9;
        repeat (20) tick();
        chk("sat4", 32'(stall4), 15);
        chk("sat16", 32'(stall16), 20);
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            fwd_en       = 1'($urandom_range(0, 1));
            id_src1      = 5'($urandom_range(0, 3));
            id_src2      = 5'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_dest     = 5'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_read = 1'($urandom_range(0, 1));
            mem_dest     = 5'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_read     = ($urandom_range(0, 5) == 0);
            mem_write    = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            sram_ack     = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/freeze sequencer for the 5-stage pipeline. It drives the enable and flush controls of the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It detects RAW hazards between the ID stage and the EXE/MEM stages, squashes wrong-path instructions on a taken branch, and freezes the whole pipeline while the MEM stage waits on a multi-cycle SRAM access via a req/ack handshake. A saturating stall counter is exposed for performance debug.

## Interface
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clock` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `fwd_en` input 1: forwarding unit active; only load-use hazards stall.
- `id_src1`, `id_src2` input 5 each: source register numbers of the instruction in ID.
- `id_two_src` input 1: ID instruction reads `id_src2`.
- `exe_dest` input 5, `exe_wb_en` input 1, `exe_mem_read` input 1: destination register, write-back enable and load flag from the ID/EXE register outputs.
- `mem_dest` input 5, `mem_wb_en` input 1: destination register and write-back enable from the EXE/MEM register outputs.
- `mem_read`, `mem_write` input 1 each: instruction in MEM accesses SRAM.
- `branch_taken` input 1: branch resolved taken in EXE.
- `sram_ack` input 1: SRAM access complete; 1-cycle pulse.
- `sram_req` output 1: SRAM request, held until ack.
- `sram_we` output 1: write qualifier for `sram_req`.
- `pc_en`, `ifid_en`, `idexe_en`, `exemem_en`, `memwb_en` output 1 each: load enables for the PC and the pipeline registers.
- `ifid_flush`, `idexe_flush` output 1 each: synchronous clear (bubble) of IF/ID and ID/EXE.
- `stall_cycles` output CNT_W: saturating count of cycles with `pc_en`=0.

## Operation
- FSM states: RUN, WAIT, RELEASE.
- **RUN**
  - If `mem_read|mem_write`: freeze this cycle, latch `sram_we`=`mem_write`, go to WAIT.
  - Otherwise stay in RUN.
- **WAIT**
  - Freeze; `sram_req`=1.
  - On `sram_ack`=1, go to RELEASE.
  - Otherwise stay in WAIT.
- **RELEASE**
  - No freeze; the pipeline advances one cycle.
  - `mem_read`/`mem_write` are ignored this cycle because they still belong to the completed instruction.
  - Always go to RUN.
- **Freeze:** all five enables = 0, both flushes = 0. Freeze has the highest priority.
- **Branch** (not frozen, `branch_taken`=1):
  - `pc_en`=1, `ifid_flush`=1, `idexe_flush`=1; other enables = 1.
  - Overrides any hazard, because the ID instruction is squashed.
- **Hazard match term:** `dest`≠0 and (`dest`==`id_src1` or (`id_two_src` and `dest`==`id_src2`)).
- **Hazard condition:**
  - `fwd_en`=0: (`exe_wb_en` and match(`exe_dest`)) or (`mem_wb_en` and match(`mem_dest`)).
  - `fwd_en`=1: only `exe_mem_read` and `exe_wb_en` and match(`exe_dest`).
- **Hazard** (not frozen, no branch): `pc_en`=0, `ifid_en`=0, `idexe_flush`=1; `idexe_en`, `exemem_en`, `memwb_en` = 1.
- **Default:** all enables = 1, flushes = 0.
- Control outputs are combinational from state and inputs. `sram_req` and `sram_we` are registered (Moore).
- **stall_cycles:**
  - Increments on each clock edge where `pc_en`=0.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - Cleared only by reset.

## Timing
- **Reset values:** state=RUN, `sram_req`=0, `sram_we`=0, `stall_cycles`=0. Combinational outputs follow the RUN rules from the current inputs.
- **Memory access:**
  - Detected in cycle N: freeze in N.
  - `sram_req`=1 from N+1.
  - `sram_ack` in cycle M (M≥N+1): `sram_req`=0 and RELEASE in M+1; the pipeline advances at the end of M+1.
  - Minimum frozen cycles: 2 (N and N+1).
  - `sram_ack` outside WAIT is ignored.
- **Branch during freeze:** held in EXE; the flush is issued on the first unfrozen cycle (RELEASE).
- **Hazard during freeze:** no effect until unfrozen.
- **Simultaneous access and branch in RUN:** freeze wins; the branch flush is applied in RELEASE.
- **Reset mid-WAIT:** `sram_req` drops asynchronously; state=RUN.
- **Back-to-back memory instructions:** the second is detected in the RUN cycle after RELEASE.
- Register 0 never creates a hazard.

## Test plan
- **No hazard.** Stimulus: reset, `id_src1`=3, `exe_dest`=5, no memory access or branch. Response: all enables = 1, flushes = 0, `stall_cycles`=0.
- **RAW hazard without forwarding.** Stimulus: `fwd_en`=0, `exe_wb_en`=1, `exe_dest`=4, `id_src1`=4 for 1 cycle. Response: `pc_en`=0, `ifid_en`=0, `idexe_flush`=1; `stall_cycles`=1. Repeat with `id_src2`=4 and `id_two_src`=0: no stall. Repeat with `exe_dest`=0: no stall.
- **Forwarding enabled.** Stimulus: `fwd_en`=1, ALU producer `exe_dest`=7=`id_src1`. Response: no stall. Then set `exe_mem_read`=1. Response: stall one cycle.
- **Load with 3-cycle SRAM wait.** Stimulus: `mem_read` in cycle 0; `sram_ack` in cycle 3. Response: freeze in cycles 0–3; `sram_req`=1 in cycles 1–3; `sram_we`=0; RELEASE in cycle 4 with enables = 1; `stall_cycles`=4.
- **Branch during store wait.** Stimulus: `mem_write` and `branch_taken` both high in cycle 0; `sram_ack` in cycle 1. Response: `sram_we`=1; frozen in cycles 0–1; `ifid_flush`=`idexe_flush`=1 in cycle 2 only.
- **Reset and saturation.** Stimulus: reset low while in WAIT. Response: `sram_req`=0 immediately and `stall_cycles`=0. Then with CNT_W=4, hold a hazard for 20 cycles. Response: `stall_cycles` stays at 15.
